// File: rtl/carfield_domain_seq_pkg.sv
// Shared types and default timing constants for the Carfield domain power sequencer.
package carfield_domain_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PU_CLK,
        PU_RST,
        PU_ISO,
        PD_ISO,
        PD_RST
    } seq_state_e;

    localparam int unsigned DefNumDomains    = 4;
    localparam int unsigned DefClkWaitCycles = 8;
    localparam int unsigned DefRstWaitCycles = 16;
    localparam int unsigned DefIsoTimeout    = 256;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A single domain still needs a 1-bit index signal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/carfield_domain_rr_pick.sv
// Combinational round-robin pick: first pending domain at or after ptr_i, wrapping.
module carfield_domain_rr_pick #(
    parameter int unsigned NumDomains = 4,
    parameter int unsigned IdxWidth   = 2
) (
    input  logic [NumDomains-1:0] pending_i,
    input  logic [IdxWidth-1:0]   ptr_i,
    output logic                  valid_o,
    output logic [IdxWidth-1:0]   idx_o
);

    int unsigned cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned off = 0; off < NumDomains; off++) begin
            cand = (32'(ptr_i) + off) % NumDomains;
            if (!valid_o && pending_i[cand[IdxWidth-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IdxWidth-1:0];
            end
        end
    end

endmodule

// File: rtl/carfield_domain_sequencer.sv
// Power-up/down sequencer for the Carfield isolatable domains: one shared FSM drives the
// clock gate, reset and AXI isolation of whichever domain the round-robin picker selects.
module carfield_domain_sequencer
    import carfield_domain_seq_pkg::*;
#(
    parameter int unsigned NumDomains    = DefNumDomains,
    parameter int unsigned ClkWaitCycles = DefClkWaitCycles,
    parameter int unsigned RstWaitCycles = DefRstWaitCycles,
    parameter int unsigned IsoTimeout    = DefIsoTimeout,
    localparam int unsigned CntWidth =
        $clog2(max3(ClkWaitCycles, RstWaitCycles, IsoTimeout)) + 1,
    localparam int unsigned IdxWidth = idx_width(NumDomains)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumDomains-1:0] domain_en_i,
    input  logic [NumDomains-1:0] isolated_i,
    input  logic [NumDomains-1:0] err_clr_i,
    output logic [NumDomains-1:0] clk_en_o,
    output logic [NumDomains-1:0] rst_no,
    output logic [NumDomains-1:0] isolate_o,
    output logic [NumDomains-1:0] domain_on_o,
    output logic [NumDomains-1:0] err_o,
    output logic                  busy_o,
    output logic [IdxWidth-1:0]   active_idx_o
);

    localparam logic [CntWidth-1:0] ClkLast = CntWidth'(ClkWaitCycles - 1);
    localparam logic [CntWidth-1:0] RstLast = CntWidth'(RstWaitCycles - 1);
    localparam logic [CntWidth-1:0] IsoLast = CntWidth'(IsoTimeout - 1);
    localparam logic [IdxWidth-1:0] IdxLast = IdxWidth'(NumDomains - 1);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    seq_state_e             state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [IdxWidth-1:0]    idx_q, idx_d;
    logic [IdxWidth-1:0]    ptr_q, ptr_d;
    logic [NumDomains-1:0]  clk_en_q, clk_en_d;
    logic [NumDomains-1:0]  rst_n_q, rst_n_d;
    logic [NumDomains-1:0]  iso_q, iso_d;
    logic [NumDomains-1:0]  on_q, on_d;
    logic [NumDomains-1:0]  err_q, err_d;
    logic [NumDomains-1:0]  err_set;
    logic                   busy_q, busy_d;

    logic [NumDomains-1:0]  pending;
    logic                   pick_valid;
    logic [IdxWidth-1:0]    pick_idx;

    assign pending = domain_en_i ^ on_q;

    carfield_domain_rr_pick #(
        .NumDomains (NumDomains),
        .IdxWidth   (IdxWidth)
    ) u_rr_pick (
        .pending_i (pending),
        .ptr_i     (ptr_q),
        .valid_o   (pick_valid),
        .idx_o     (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        clk_en_d = clk_en_q;
        rst_n_d  = rst_n_q;
        iso_d    = iso_q;
        on_d     = on_q;
        err_set  = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d = pick_idx;
                    // ptr holds the index the next search starts from.
                    ptr_d = (pick_idx == IdxLast) ? '0 : pick_idx + IdxWidth'(1);
                    cnt_d = '0;
                    if (!on_q[pick_idx]) begin
                        clk_en_d[pick_idx] = 1'b1;
                        state_d            = PU_CLK;
                    end else begin
                        iso_d[pick_idx] = 1'b1;
                        on_d[pick_idx]  = 1'b0;
                        state_d         = PD_ISO;
                    end
                end
            end
            PU_CLK: begin
                if (cnt_q == ClkLast) begin
                    rst_n_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    state_d        = PU_RST;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            PU_RST: begin
                if (cnt_q == RstLast) begin
                    iso_d[idx_q] = 1'b0;
                    cnt_d        = '0;
                    state_d      = PU_ISO;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            PU_ISO: begin
                if (!isolated_i[idx_q] || cnt_q == IsoLast) begin
                    on_d[idx_q]    = 1'b1;
                    err_set[idx_q] = isolated_i[idx_q];
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            PD_ISO: begin
                if (isolated_i[idx_q] || cnt_q == IsoLast) begin
                    rst_n_d[idx_q] = 1'b0;
                    err_set[idx_q] = !isolated_i[idx_q];
                    cnt_d          = '0;
                    state_d        = PD_RST;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            PD_RST: begin
                if (cnt_q == RstLast) begin
                    clk_en_d[idx_q] = 1'b0;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout in the same cycle as a clear wins.
        err_d  = (err_q & ~err_clr_i) | err_set;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            clk_en_q <= '0;
            rst_n_q  <= '0;
            iso_q    <= '1;
            on_q     <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            clk_en_q <= clk_en_d;
            rst_n_q  <= rst_n_d;
            iso_q    <= iso_d;
            on_q     <= on_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign clk_en_o     = clk_en_q;
    assign rst_no       = rst_n_q;
    assign isolate_o    = iso_q;
    assign domain_on_o  = on_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign active_idx_o = idx_q;

endmodule

// File: tb/tb_carfield_domain_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline-based model.
module tb_carfield_domain_sequencer;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int RW = 16;
    localparam int IT = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] en, iso_ack, clr;
    logic [N-1:0] clk_en, rst_n, isolate, on, err;
    logic         busy;
    logic [1:0]   aidx;

    carfield_domain_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .domain_en_i  (en),
        .isolated_i   (iso_ack),
        .err_clr_i    (clr),
        .clk_en_o     (clk_en),
        .rst_no       (rst_n),
        .isolate_o    (isolate),
        .domain_on_o  (on),
        .err_o        (err),
        .busy_o       (busy),
        .active_idx_o (aidx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: a sequence is described by elapsed edges since its pick edge.
    logic [N-1:0] m_clk, m_rstn, m_iso, m_on, m_err;
    logic         m_busy, m_up;
    int           m_idx, m_ptr, m_t, m_k;

    task automatic model_reset();
        m_clk = '0; m_rstn = '0; m_iso = '1; m_on = '0; m_err = '0;
        m_busy = 1'b0; m_up = 1'b0; m_idx = 0; m_ptr = 0; m_t = 0; m_k = -1;
    endtask

    task automatic model_edge();
        logic [N-1:0] set;
        bit found;
        int i, w;
        set = '0;
        found = 0;
        if (!m_busy) begin
            for (int o = 0; o < N; o++) begin
                int c;
                c = (m_ptr + o) % N;
                if (!found && (en[c] != m_on[c])) begin
                    found = 1;
                    m_idx = c;
                end
            end
            if (found) begin
                m_ptr  = (m_idx + 1) % N;
                m_t    = 0;
                m_k    = -1;
                m_busy = 1'b1;
                m_up   = !m_on[m_idx];
                if (m_up) m_clk[m_idx] = 1'b1;
                else begin
                    m_iso[m_idx] = 1'b1;
                    m_on[m_idx]  = 1'b0;
                end
            end
        end else begin
            i = m_idx;
            m_t++;
            if (m_up) begin
                if (m_t == CW) m_rstn[i] = 1'b1;
                else if (m_t == CW + RW) m_iso[i] = 1'b0;
                else if (m_t > CW + RW) begin
                    w = m_t - (CW + RW + 1);
                    if (!iso_ack[i] || w == IT - 1) begin
                        m_on[i] = 1'b1;
                        set[i]  = iso_ack[i];
                        m_busy  = 1'b0;
                    end
                end
            end else begin
                if (m_k < 0) begin
                    w = m_t - 1;
                    if (iso_ack[i] || w == IT - 1) begin
                        m_rstn[i] = 1'b0;
                        set[i]    = !iso_ack[i];
                        m_k       = m_t;
                    end
                end else if (m_t == m_k + RW) begin
                    m_clk[i] = 1'b0;
                    m_busy   = 1'b0;
                end
            end
        end
        m_err = (m_err & ~clr) | set;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if ({clk_en, rst_n, isolate, on, err, busy, aidx} !==
            {m_clk, m_rstn, m_iso, m_on, m_err, m_busy, 2'(m_idx)}) begin
            failures++;
            $display("FAIL %s model: got clk=%b rstn=%b iso=%b on=%b err=%b busy=%b idx=%0d want clk=%b rstn=%b iso=%b on=%b err=%b busy=%b idx=%0d",
                     tag, clk_en, rst_n, isolate, on, err, busy, aidx,
                     m_clk, m_rstn, m_iso, m_on, m_err, m_busy, m_idx);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; clr = '0; iso_ack = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({clk_en, rst_n, isolate, on, err, busy, aidx} !== {4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_values: got clk=%b rstn=%b iso=%b on=%b err=%b busy=%b idx=%0d want 0000 0000 1111 0000 0000 0 0",
                     clk_en, rst_n, isolate, on, err, busy, aidx);
        end
    endtask

    task automatic test_power_up_down();
        int t_clk = 0, t_rst = 0, t_iso = 0, t_on = 0, n;
        do_reset();
        en[1] = 1'b1;
        for (int s = 1; s <= 60 && t_on == 0; s++) begin
            if (t_iso > 0 && s == t_iso + 3) iso_ack[1] = 1'b0;
            step("pu1");
            if (t_clk == 0 && clk_en[1]) t_clk = s;
            if (t_rst == 0 && rst_n[1]) t_rst = s;
            if (t_iso == 0 && t_rst > 0 && !isolate[1]) t_iso = s;
            if (t_on == 0 && on[1]) t_on = s;
        end
        expect_int("pu_clk_en_latency", t_clk, 1);
        expect_int("pu_rst_after_clk", t_rst - t_clk, CW);
        expect_int("pu_iso_after_rst", t_iso - t_rst, RW);
        expect_int("pu_on_after_iso", t_on - t_iso, 3);
        expect_bit("pu_err_clear", err[1], 1'b0);

        en[1] = 1'b0;
        iso_ack[1] = 1'b1;
        step("pd1_pick");
        expect_bit("pd_isolate_at_pick", isolate[1], 1'b1);
        expect_bit("pd_on_low_at_pick", on[1], 1'b0);
        step("pd1_rst");
        expect_bit("pd_rst_low", rst_n[1], 1'b0);
        n = 0;
        while (clk_en[1] && n < 40) begin
            step("pd1_wait");
            n++;
        end
        expect_int("pd_clk_off_latency", n, RW);
        expect_bit("pd_busy_low", busy, 1'b0);
    endtask

    task automatic test_back_to_back();
        int order[$];
        logic prev_busy = 1'b0;
        bit overlap = 0;
        do_reset();
        en = 4'hF;
        iso_ack = '0;
        for (int s = 0; s < 200 && on != 4'hF; s++) begin
            step("b2b");
            if (busy && !prev_busy) order.push_back(int'(aidx));
            if ($countones(clk_en & ~on) > 1) overlap = 1;
            prev_busy = busy;
        end
        expect_int("b2b_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) expect_int("b2b_order", order[i], i);
        expect_bit("b2b_overlap", overlap, 1'b0);
    endtask

    task automatic test_timeout();
        int t_iso = 0, t_on = 0;
        do_reset();
        en[2] = 1'b1;
        iso_ack[2] = 1'b1;
        for (int s = 1; s <= 400 && t_on == 0; s++) begin
            step("to_pu");
            if (t_iso == 0 && rst_n[2] && !isolate[2]) t_iso = s;
            if (on[2]) t_on = s;
        end
        expect_int("to_pu_wait", t_on - t_iso, IT);
        expect_bit("to_err_set", err[2], 1'b1);
        clr[2] = 1'b1;
        step("to_clr");
        clr[2] = 1'b0;
        expect_bit("to_err_cleared", err[2], 1'b0);

        en[2] = 1'b0;
        iso_ack[2] = 1'b0;
        step("to_pd_pick");
        repeat (IT - 1) step("to_pd_wait");
        clr[2] = 1'b1;
        step("to_pd_timeout");
        clr[2] = 1'b0;
        expect_bit("to_set_beats_clr", err[2], 1'b1);
        expect_bit("to_pd_rst_low", rst_n[2], 1'b0);
        repeat (RW + 2) step("to_pd_rst");
        expect_bit("to_pd_clk_off", clk_en[2], 1'b0);
    endtask

    task automatic test_toggle_mid_sequence();
        do_reset();
        en[0] = 1'b1;
        iso_ack[0] = 1'b0;
        repeat (12) step("tog_pu");
        en[0] = 1'b0;
        repeat (14) step("tog_pu_rest");
        expect_bit("tog_on_after_pu", on[0], 1'b1);
        step("tog_pd_pick");
        expect_bit("tog_pd_isolate", isolate[0], 1'b1);
        expect_bit("tog_pd_busy", busy, 1'b1);
        iso_ack[0] = 1'b1;
        repeat (RW + 2) step("tog_pd");
        expect_bit("tog_clk_off", clk_en[0], 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        en[3] = 1'b1;
        iso_ack[3] = 1'b0;
        repeat (12) step("ar_pu");
        expect_bit("ar_in_pu_rst", rst_n[3], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({clk_en, rst_n, isolate, on, err, busy, aidx} !== {4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL async_reset: got clk=%b rstn=%b iso=%b on=%b busy=%b idx=%0d want all off and isolated",
                     clk_en, rst_n, isolate, on, busy, aidx);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("ar_restart");
        expect_bit("ar_restart_clk", clk_en[3], 1'b1);
        expect_bit("ar_restart_rst_held", rst_n[3], 1'b0);
        repeat (30) step("ar_finish");
        expect_bit("ar_on", on[3], 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, N - 1)] ^= 1'b1;
            clr = ($urandom_range(0, 19) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            for (int i = 0; i < N; i++)
                iso_ack[i] = ($urandom_range(0, 3) != 0) ? m_iso[i] : 1'($urandom_range(0, 1));
            step("random");
        end
    endtask

    initial begin
        rst = 1'b1; en = '0; clr = '0; iso_ack = '1;
        model_reset();
        test_reset();
        test_power_up_down();
        test_back_to_back();
        test_timeout();
        test_toggle_mid_sequence();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
